// File: rtl/mc_controller.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB FSM with Moore strobes decoded from a latched instruction.
// Optional retired-instruction counter (out_retired) enabled by defining MC_CTRL_RETIRE_CNT_EN.
module mc_controller #(
    parameter int unsigned FETCH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_instr,
    input  logic        in_zero,
    output logic        out_IR_WE,
    output logic        out_PC_WE,
    output logic        out_IFU_SRC,
    output logic [1:0]  out_IFU_nPC_sel,
    output logic        out_GRF_WE,
    output logic        out_DM_WE,
    output logic        out_ALU_src,
    output logic [1:0]  out_GRF_WD,
    output logic [1:0]  out_GRF_WS,
    output logic [1:0]  out_ALU_option,
    output logic [1:0]  out_EXT_option,
    output logic [2:0]  out_state
`ifdef MC_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] out_retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL
    } cls_e;

    localparam logic [3:0] LAST_CNT = 4'(FETCH_CYCLES - 1);

    state_e      state_q, state_next;
    logic [3:0]  fetch_cnt, cnt_next;
    logic [31:0] instr_q;
    logic        ir_we;
    cls_e        cls;
    state_e      final_state;

    // in_zero is consumed by the IFU; only the opcode/funct fields of the latched word matter here.
    logic unused_bits;
    assign unused_bits = ^{in_zero, instr_q[25:6]};

    assign ir_we = (state_q == S_FETCH) && (fetch_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            fetch_cnt <= 4'd0;
            instr_q   <= 32'h0000_0000;
        end else begin
            state_q   <= state_next;
            fetch_cnt <= cnt_next;
            if (ir_we) instr_q <= in_instr;
        end
    end

    always_comb begin
        cls = C_NOP;
        case (instr_q[31:26])
            6'h00: begin
                case (instr_q[5:0])
                    6'h21:   cls = C_ADDU;
                    6'h23:   cls = C_SUBU;
                    6'h08:   cls = C_JR;
                    default: cls = C_NOP;
                endcase
            end
            6'h0D:   cls = C_ORI;
            6'h23:   cls = C_LW;
            6'h2B:   cls = C_SW;
            6'h04:   cls = C_BEQ;
            6'h0F:   cls = C_LUI;
            6'h03:   cls = C_JAL;
            default: cls = C_NOP;
        endcase
    end

    always_comb begin
        final_state = S_WB;
        case (cls)
            C_NOP:        final_state = S_DECODE;
            C_BEQ, C_JR:  final_state = S_EXEC;
            C_SW:         final_state = S_MEM;
            default:      final_state = S_WB;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        cnt_next   = 4'd0;
        case (state_q)
            S_FETCH: begin
                if (ir_we) begin
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                    cnt_next   = fetch_cnt + 4'd1;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_NOP:   state_next = S_FETCH;
                    C_JAL:   state_next = S_WB;
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_ADDU, C_SUBU, C_ORI, C_LUI: state_next = S_WB;
                    C_LW, C_SW:                   state_next = S_MEM;
                    default:                      state_next = S_FETCH;
                endcase
            end
            S_MEM:   state_next = (cls == C_LW) ? S_WB : S_FETCH;
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        // IR_WE is gated by reset so every output reads 0 while reset is held.
        out_IR_WE       = reset & ir_we;
        out_PC_WE       = 1'b0;
        out_IFU_SRC     = 1'b0;
        out_IFU_nPC_sel = 2'd0;
        out_GRF_WE      = 1'b0;
        out_DM_WE       = 1'b0;
        out_ALU_src     = 1'b0;
        out_GRF_WD      = 2'd0;
        out_GRF_WS      = 2'd0;
        out_ALU_option  = 2'd0;
        out_EXT_option  = 2'd0;
        out_state       = state_q;

        if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            case (cls)
                C_SUBU, C_BEQ: out_ALU_option = 2'd1;
                C_ORI: begin
                    out_ALU_option = 2'd2;
                    out_ALU_src    = 1'b1;
                end
                C_LUI: begin
                    out_ALU_option = 2'd2;
                    out_ALU_src    = 1'b1;
                    out_EXT_option = 2'd2;
                end
                C_LW, C_SW: begin
                    out_ALU_src    = 1'b1;
                    out_EXT_option = 2'd1;
                end
                default: ;
            endcase
        end

        if (state_q == S_WB) begin
            out_GRF_WE = 1'b1;
            case (cls)
                C_ADDU, C_SUBU: out_GRF_WD = 2'd1;
                C_LW:           out_GRF_WS = 2'd1;
                C_JAL: begin
                    out_GRF_WD = 2'd2;
                    out_GRF_WS = 2'd2;
                end
                default: ;
            endcase
        end

        if (state_q == S_MEM && cls == C_SW) out_DM_WE = 1'b1;

        if (state_q == final_state) begin
            out_PC_WE = 1'b1;
            case (cls)
                C_BEQ: out_IFU_nPC_sel = 2'd1;
                C_JAL: out_IFU_nPC_sel = 2'd2;
                C_JR: begin
                    out_IFU_nPC_sel = 2'd3;
                    out_IFU_SRC     = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_q <= 32'd0;
        end else if (out_PC_WE) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign out_retired = retire_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: FETCH_CYCLES=1 instance for instruction sequences,
// FETCH_CYCLES=3 instance for mid-instruction reset; retire counter checked when MC_CTRL_RETIRE_CNT_EN is set.
module tb_mc_controller;

    localparam logic [31:0] I_ADDU = 32'h0085_1021;
    localparam logic [31:0] I_SUBU = 32'h00A4_1023;
    localparam logic [31:0] I_LW   = 32'h8C43_0004;
    localparam logic [31:0] I_SW   = 32'hAC43_0004;
    localparam logic [31:0] I_BEQ  = 32'h10A0_0003;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_ORI  = 32'h34A5_0FFF;
    localparam logic [31:0] I_LUI  = 32'h3C05_1234;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;
    localparam logic [31:0] I_NOP  = 32'h0000_0000;

    logic        clk;
    logic        rst1, rst3;
    logic [31:0] in_instr;
    logic        in_zero;

    int checks = 0;
    int errors = 0;

    logic        a_ir, a_pc, a_src, a_gwe, a_dwe, a_asrc;
    logic [1:0]  a_npc, a_wd, a_ws, a_op, a_ext;
    logic [2:0]  a_st;
    logic        b_ir, b_pc, b_src, b_gwe, b_dwe, b_asrc;
    logic [1:0]  b_npc, b_wd, b_ws, b_op, b_ext;
    logic [2:0]  b_st;
    logic [18:0] obs1, obs3;
`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [31:0] ret1, ret3;
`endif

    assign obs1 = {a_st, a_ir, a_pc, a_src, a_npc, a_gwe, a_dwe, a_asrc, a_wd, a_ws, a_op, a_ext};
    assign obs3 = {b_st, b_ir, b_pc, b_src, b_npc, b_gwe, b_dwe, b_asrc, b_wd, b_ws, b_op, b_ext};

    mc_controller #(.FETCH_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst1), .in_instr(in_instr), .in_zero(in_zero),
        .out_IR_WE(a_ir), .out_PC_WE(a_pc), .out_IFU_SRC(a_src), .out_IFU_nPC_sel(a_npc),
        .out_GRF_WE(a_gwe), .out_DM_WE(a_dwe), .out_ALU_src(a_asrc),
        .out_GRF_WD(a_wd), .out_GRF_WS(a_ws), .out_ALU_option(a_op), .out_EXT_option(a_ext),
        .out_state(a_st)
`ifdef MC_CTRL_RETIRE_CNT_EN
        , .out_retired(ret1)
`endif
    );

    mc_controller #(.FETCH_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst3), .in_instr(in_instr), .in_zero(in_zero),
        .out_IR_WE(b_ir), .out_PC_WE(b_pc), .out_IFU_SRC(b_src), .out_IFU_nPC_sel(b_npc),
        .out_GRF_WE(b_gwe), .out_DM_WE(b_dwe), .out_ALU_src(b_asrc),
        .out_GRF_WD(b_wd), .out_GRF_WS(b_ws), .out_ALU_option(b_op), .out_EXT_option(b_ext),
        .out_state(b_st)
`ifdef MC_CTRL_RETIRE_CNT_EN
        , .out_retired(ret3)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted finish");
        $fatal(1, "watchdog expired");
    end

    // pack expected outputs in the same order as obs1/obs3
    function automatic logic [18:0] pk(input logic [2:0] st, input logic ir, input logic pc,
                                       input logic src, input logic [1:0] npc, input logic gwe,
                                       input logic dwe, input logic asrc, input logic [1:0] wd,
                                       input logic [1:0] ws, input logic [1:0] op, input logic [1:0] ext);
        return {st, ir, pc, src, npc, gwe, dwe, asrc, wd, ws, op, ext};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, wanted %h", tag, act, exp);
        end
    endtask

    // check the selected instance in the current cycle, then move to the next cycle
    task automatic cyc(input string tag, input bit sel3, input logic [18:0] exp);
        check_val(tag, sel3 ? {13'd0, obs3} : {13'd0, obs1}, {13'd0, exp});
        @(posedge clk);
        #2;
    endtask

    localparam logic [18:0] F_IR   = 19'h0_0000 | (19'd1 << 15);
    localparam logic [18:0] F_IDLE = 19'd0;

    initial begin
        rst1 = 1'b0;
        rst3 = 1'b0;
        in_instr = I_ADDU;
        in_zero = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_val("rst_d1", {13'd0, obs1}, 32'd0);
        check_val("rst_d3", {13'd0, obs3}, 32'd0);
`ifdef MC_CTRL_RETIRE_CNT_EN
        check_val("rst_ret", ret1, 32'd0);
`endif
        rst1 = 1'b1;
        #1;

        // addu; input word changes after FETCH to prove decode uses the latched copy
        cyc("addu_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        in_instr = I_JAL;
        cyc("addu_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("addu_e", 0, pk(2,0,0,0,0,0,0,0,0,0,0,0));
        cyc("addu_w", 0, pk(4,0,1,0,0,1,0,0,1,0,0,0));

        in_instr = I_LW;
        cyc("lw_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lw_e", 0, pk(2,0,0,0,0,0,0,1,0,0,0,1));
        cyc("lw_m", 0, pk(3,0,0,0,0,0,0,1,0,0,0,1));
        cyc("lw_w", 0, pk(4,0,1,0,0,1,0,1,0,1,0,1));

        in_instr = I_SW;
        cyc("sw_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("sw_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("sw_e", 0, pk(2,0,0,0,0,0,0,1,0,0,0,1));
        cyc("sw_m", 0, pk(3,0,1,0,0,0,1,1,0,0,0,1));

        // beq twice: in_zero toggling, then held high
        in_instr = I_BEQ;
        for (int r = 0; r < 2; r++) begin
            in_zero = (r == 0) ? ~in_zero : 1'b1;
            cyc("beq_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
            in_zero = (r == 0) ? ~in_zero : 1'b1;
            cyc("beq_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
            in_zero = (r == 0) ? ~in_zero : 1'b1;
            cyc("beq_e", 0, pk(2,0,1,0,1,0,0,0,0,0,1,0));
        end
        in_zero = 1'b0;

        in_instr = I_JAL;
        cyc("jal_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("jal_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("jal_w", 0, pk(4,0,1,0,2,1,0,0,2,2,0,0));

        in_instr = I_JR;
        cyc("jr_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("jr_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("jr_e", 0, pk(2,0,1,1,3,0,0,0,0,0,0,0));

        in_instr = I_BAD;
        cyc("bad_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("bad_d", 0, pk(1,0,1,0,0,0,0,0,0,0,0,0));

        in_instr = I_ORI;
        cyc("ori_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("ori_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("ori_e", 0, pk(2,0,0,0,0,0,0,1,0,0,2,0));
        cyc("ori_w", 0, pk(4,0,1,0,0,1,0,1,0,0,2,0));

        in_instr = I_LUI;
        cyc("lui_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("lui_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("lui_e", 0, pk(2,0,0,0,0,0,0,1,0,0,2,2));
        cyc("lui_w", 0, pk(4,0,1,0,0,1,0,1,0,0,2,2));

        in_instr = I_SUBU;
        cyc("subu_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("subu_d", 0, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("subu_e", 0, pk(2,0,0,0,0,0,0,0,0,0,1,0));
        cyc("subu_w", 0, pk(4,0,1,0,0,1,0,0,1,0,1,0));

`ifdef MC_CTRL_RETIRE_CNT_EN
        in_instr = I_NOP;
        force dut1.retire_q = 32'hFFFF_FFFE;
        #1;
        release dut1.retire_q;
        cyc("nop1_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("nop1_d", 0, pk(1,0,1,0,0,0,0,0,0,0,0,0));
        check_val("ret_1", ret1, 32'hFFFF_FFFF);
        cyc("nop2_f", 0, pk(0,1,0,0,0,0,0,0,0,0,0,0));
        cyc("nop2_d", 0, pk(1,0,1,0,0,0,0,0,0,0,0,0));
        check_val("ret_2", ret1, 32'h0000_0000);
`endif

        // FETCH_CYCLES=3 instance: lw interrupted by reset in MEM
        in_instr = I_LW;
        rst3 = 1'b1;
        #1;
        cyc("f3_c0", 1, F_IDLE);
        cyc("f3_c1", 1, F_IDLE);
        cyc("f3_c2", 1, F_IR);
        cyc("f3_d", 1, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("f3_e", 1, pk(2,0,0,0,0,0,0,1,0,0,0,1));
        check_val("f3_mem", {13'd0, obs3}, {13'd0, pk(3,0,0,0,0,0,0,1,0,0,0,1)});
        rst3 = 1'b0;
        #1;
        check_val("f3_rst_now", {13'd0, obs3}, 32'd0);
        @(posedge clk);
        #2;
        check_val("f3_rst_hold", {13'd0, obs3}, 32'd0);
        rst3 = 1'b1;
        #1;
        cyc("f3_r0", 1, F_IDLE);
        cyc("f3_r1", 1, F_IDLE);
        cyc("f3_r2", 1, F_IR);
        cyc("f3_rd", 1, pk(1,0,0,0,0,0,0,0,0,0,0,0));
        cyc("f3_re", 1, pk(2,0,0,0,0,0,0,1,0,0,0,1));
        cyc("f3_rm", 1, pk(3,0,0,0,0,0,0,1,0,0,0,1));
        cyc("f3_rw", 1, pk(4,0,1,0,0,1,0,1,0,1,0,1));
        cyc("f3_next", 1, F_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
